uart_rx: RTL and testbench

UART serial receiver that consumes the 16x-oversampling tick from the baud rate generator and recovers 8N1-style frames from the `rx` line. It sits between the pad-side `rx` input and the receive FIFO or host logic. Each completed frame produces one-cycle `rx_done_tick` with the data word and error flags. Each bit is sampled once at its mid-point, located by counting 16 ticks per bit.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   state_e          : receiver FSM states, 3-bit encoded, IDLE=0 .. STOP=4
//   DBIT_DEFAULT     : default number of data bits per frame
//   SB_TICK_DEFAULT  : default number of oversampling ticks in the stop phase
//   OVS              : oversampling ticks per bit period
//   OVS_MID          : tick count that lands on the middle of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int OVS             = 16;
  localparam int OVS_MID         = 7;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, both flops load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk_i cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  // Both reset to RST_VAL so an idle-high line does not look like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver driven by a 16x oversampling tick. Finds the start bit,
// samples every following bit once at its mid-point, and reports each
// completed frame with a one-cycle done pulse plus data and error flags.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   s_tick       : one-clk pulse at 16x baud
//   rx           : asynchronous serial line, idles high
//   dout         : last received data word (LSB received first)
//   rx_done_tick : one-clk pulse when a frame completes
//   frame_err    : stop bit of the last frame was sampled low
//   parity_err   : parity mismatch on the last frame (0 when parity disabled)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int SB_TICK    = SB_TICK_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int   NW      = $clog2(DBIT);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic            rx_s;
  state_e          state_q, state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_reg_q, b_reg_d;
  logic            p_err_q, p_err_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Next-state logic. Every register holds unless its state acts on a tick;
  // IDLE alone reacts to the line level so a start edge is never missed
  // waiting for the next tick. The done pulse defaults low, so it lasts one
  // clk even when s_tick is held high.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_reg_d = b_reg_q;
    p_err_d = p_err_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = 4'd0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVS_MID)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = 4'd0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVS - 1)) begin
            s_cnt_d = 4'd0;
            b_reg_d = {rx_s, b_reg_q[DBIT-1:1]};
            if (n_cnt_q == NW'(DBIT - 1)) begin
              state_d = PAR_EN ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(OVS - 1)) begin
            p_err_d = (^{b_reg_q, rx_s}) ^ PAR_ODD;
            s_cnt_d = 4'd0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(SB_TICK - 1)) begin
            dout_d  = b_reg_q;
            ferr_d  = ~rx_s;
            perr_d  = PAR_EN ? p_err_q : 1'b0;
            done_d  = 1'b1;
            s_cnt_d = 4'd0;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset mid-frame drops the partial frame and
  // clears every reported value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= 4'd0;
      n_cnt_q <= '0;
      b_reg_q <= '0;
      p_err_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_reg_q <= b_reg_d;
      p_err_q <= p_err_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx. Instance dut0 uses the defaults (8N1); dut1 enables even
// parity. Each has its own serial line; clock, tick and reset are shared.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int  BITCLK  = 64;
  localparam logic PAR_ODD = 1'b0;

  typedef logic [9:0] rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sTick;
  logic       rx0, rx1;
  logic [7:0] dout0, dout1;
  logic       done0, done1, fe0, fe1, pe0, pe1;

  int vectors     = 0;
  int miscompares = 0;

  rec_t gotQ0[$];
  rec_t gotQ1[$];
  rec_t expQ0[$];
  rec_t expQ1[$];
  int   rd0 = 0;
  int   rd1 = 0;

  uart_rx dut0 (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (sTick),
    .rx          (rx0),
    .dout        (dout0),
    .rx_done_tick(done0),
    .frame_err   (fe0),
    .parity_err  (pe0)
  );

  uart_rx #(
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (sTick),
    .rx          (rx1),
    .dout        (dout1),
    .rx_done_tick(done1),
    .frame_err   (fe1),
    .parity_err  (pe1)
  );

  // 100 MHz-style free running clock.
  always #5 clk = ~clk;

  // Move n rising edges forward, then step off the edge so that drives and
  // samples never race the DUT flops.
  task automatic waitClk(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  // Oversampling tick: one clk high out of every four.
  initial begin
    sTick = 1'b0;
    forever begin
      waitClk(3);
      sTick = 1'b1;
      waitClk(1);
      sTick = 1'b0;
    end
  end

  // Record every completed frame as the receiver reports it.
  always @(negedge clk) begin
    if (done0) gotQ0.push_back({pe0, fe0, dout0});
    if (done1) gotQ1.push_back({pe1, fe1, dout1});
  end

  // Reference model: what a frame built from these bits must report.
  function automatic rec_t modelFrame(input logic [7:0] d, input logic pbit,
                                      input logic stopb, input bit parEn);
    logic pe;
    pe = parEn ? ((^d) ^ pbit ^ PAR_ODD) : 1'b0;
    return {pe, ~stopb, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setLine(input int line, input logic v);
    if (line == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Serialize one frame: start, 8 data bits LSB first, parity on line 1,
  // then stop. A bad stop is held low for 12 ticks then released, so the
  // receiver's level re-arm sees a short glitch rather than a new frame.
  task automatic applyStimulus(input int line, input logic [7:0] d,
                               input logic pbit, input logic stopb,
                               input int gapTicks);
    setLine(line, 1'b0);
    waitClk(BITCLK);
    for (int i = 0; i < 8; i++) begin
      setLine(line, d[i]);
      waitClk(BITCLK);
    end
    if (line == 1) begin
      setLine(line, pbit);
      waitClk(BITCLK);
    end
    if (stopb) begin
      setLine(line, 1'b1);
      waitClk(BITCLK);
    end else begin
      setLine(line, 1'b0);
      waitClk(48);
      setLine(line, 1'b1);
      waitClk(16);
    end
    if (line == 0) expQ0.push_back(modelFrame(d, pbit, stopb, 1'b0));
    else expQ1.push_back(modelFrame(d, pbit, stopb, 1'b1));
    waitClk(gapTicks * 4);
  endtask

  // Compare everything received since the last call against the model.
  task automatic checkLine(input int line, input string tag);
    rec_t got[$];
    rec_t exp[$];
    if (line == 0) begin
      for (int i = rd0; i < gotQ0.size(); i++) got.push_back(gotQ0[i]);
      rd0 = gotQ0.size();
      exp = expQ0;
      expQ0.delete();
    end else begin
      for (int i = rd1; i < gotQ1.size(); i++) got.push_back(gotQ1[i]);
      rd1 = gotQ1.size();
      exp = expQ1;
      expQ1.delete();
    end
    checkOutput($sformatf("%s frames", tag), 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) begin
        checkOutput($sformatf("%s[%0d] dout", tag, i), 32'(got[i][7:0]), 32'(exp[i][7:0]));
        checkOutput($sformatf("%s[%0d] frame_err", tag, i), 32'(got[i][8]), 32'(exp[i][8]));
        checkOutput($sformatf("%s[%0d] parity_err", tag, i), 32'(got[i][9]), 32'(exp[i][9]));
      end
    end
  endtask

  logic [7:0] rd;
  logic       rs, rp;
  int         rl;

  initial begin
    reset = 1'b1;
    rx0   = 1'b1;
    rx1   = 1'b1;
    waitClk(5);

    $display("[TB] reset values");
    checkOutput("reset dout", 32'(dout0), 32'h0);
    checkOutput("reset done", 32'(done0), 32'h0);
    checkOutput("reset frame_err", 32'(fe0), 32'h0);
    checkOutput("reset parity_err", 32'(pe0), 32'h0);
    checkOutput("reset state", 32'(dut0.state_q), 32'(IDLE));
    reset = 1'b0;
    waitClk(20);

    $display("[TB] frame 0xA5");
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 20);
    checkLine(0, "a5");
    checkOutput("a5 held dout", 32'(dout0), 32'hA5);

    $display("[TB] short start glitch");
    setLine(0, 1'b0);
    waitClk(20);
    setLine(0, 1'b1);
    waitClk(160);
    checkLine(0, "glitch");
    checkOutput("glitch dout", 32'(dout0), 32'hA5);
    checkOutput("glitch state", 32'(dut0.state_q), 32'(IDLE));

    $display("[TB] framing error then recovery");
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 40);
    checkLine(0, "ferr");
    checkOutput("ferr held flag", 32'(fe0), 32'h1);
    applyStimulus(0, 8'h11, 1'b0, 1'b1, 20);
    checkLine(0, "ferr clear");
    checkOutput("ferr cleared flag", 32'(fe0), 32'h0);

    $display("[TB] even parity");
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 20);
    checkLine(1, "par good");
    checkOutput("par good flag", 32'(pe1), 32'h0);
    applyStimulus(1, 8'h07, 1'b0, 1'b1, 20);
    checkLine(1, "par bad");
    checkOutput("par bad flag", 32'(pe1), 32'h1);

    $display("[TB] back-to-back frames");
    applyStimulus(0, 8'h00, 1'b0, 1'b1, 0);
    applyStimulus(0, 8'hFF, 1'b0, 1'b1, 20);
    checkLine(0, "b2b");

    $display("[TB] reset during data bit 4");
    setLine(0, 1'b0);
    waitClk(BITCLK);
    for (int i = 0; i < 4; i++) begin
      setLine(0, 1'(8'hC3 >> i));
      waitClk(BITCLK);
    end
    setLine(0, 1'b0);
    waitClk(32);
    reset = 1'b1;
    waitClk(2);
    checkOutput("abort dout", 32'(dout0), 32'h0);
    checkOutput("abort done", 32'(done0), 32'h0);
    checkOutput("abort frame_err", 32'(fe0), 32'h0);
    checkOutput("abort parity_err", 32'(pe0), 32'h0);
    setLine(0, 1'b1);
    waitClk(2);
    reset = 1'b0;
    waitClk(BITCLK * 4);
    checkOutput("abort state", 32'(dut0.state_q), 32'(IDLE));
    checkLine(0, "abort");
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 20);
    checkLine(0, "after abort");

    $display("[TB] randomized frames");
    for (int n = 0; n < 16; n++) begin
      rl = int'($urandom_range(0, 1));
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus(rl, rd, rp, rs, int'($urandom_range(8, 24)));
      checkLine(rl, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
